// File: rtl/priority_encoder_top.sv
// Sparse-match index generator: ANDs two occupancy bitmaps and emits the index
// of every common set bit, lowest first, one index per clock.
module priority_encoder_top #(
    parameter int unsigned SIZE = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    valid_i,
    input  logic [SIZE-1:0]         in1_i,
    input  logic [SIZE-1:0]         in2_i,
    output logic                    valid_o,
    output logic [$clog2(SIZE)-1:0] match_addr_o,
    output logic                    pri_enc_last_o
);

    localparam int unsigned AW = $clog2(SIZE);

    logic [SIZE-1:0] rem_q, rem_d;
    logic            zero_q, zero_d;
    logic [SIZE-1:0] next_rem;
    logic [SIZE-1:0] match_vec;
    logic            found;
    logic            ready;

    assign match_vec = in1_i & in2_i;

    always_comb begin
        valid_o      = |rem_q;
        match_addr_o = '0;
        found        = 1'b0;
        for (int unsigned i = 0; i < SIZE; i++) begin
            if (!found && rem_q[i]) begin
                match_addr_o = AW'(i);
                found        = 1'b1;
            end
        end
        next_rem       = rem_q & (rem_q - SIZE'(1));
        pri_enc_last_o = (valid_o && (next_rem == '0)) || zero_q;
    end

    // A new pair is accepted when idle or on the final cycle of the current
    // vector, giving back-to-back scans with no bubble.
    always_comb begin
        ready = ((rem_q == '0) && !zero_q) || pri_enc_last_o;
        if (ready && valid_i) begin
            rem_d  = match_vec;
            zero_d = (match_vec == '0);
        end else begin
            rem_d  = next_rem;
            zero_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rem_q  <= '0;
            zero_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            zero_q <= zero_d;
        end
    end

endmodule

// File: tb/tb_priority_encoder_top.sv
// Bench for priority_encoder_top: queue-based reference model checked every
// cycle, plus directed scenarios with literal expected index sequences.
module tb_priority_encoder_top;

    localparam int unsigned SIZE = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       vin = 1'b0;
    logic [7:0] a   = '0;
    logic [7:0] b   = '0;
    logic       vout;
    logic [2:0] addr;
    logic       last;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Model: pending indices still to be emitted, plus the all-zero marker.
    int q[$];
    bit mzero = 1'b0;

    priority_encoder_top #(.SIZE(SIZE)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .valid_i       (vin),
        .in1_i         (a),
        .in2_i         (b),
        .valid_o       (vout),
        .match_addr_o  (addr),
        .pri_enc_last_o(last)
    );

    always #5 clk = ~clk;

    function automatic logic m_valid();
        return q.size() > 0;
    endfunction

    function automatic logic [2:0] m_addr();
        return (q.size() > 0) ? 3'(q[0]) : 3'd0;
    endfunction

    function automatic logic m_last();
        return (q.size() == 1) || mzero;
    endfunction

    always @(posedge clk) begin
        logic [7:0] m;
        bit rdy;
        if (rst) begin
            q.delete();
            mzero = 1'b0;
        end else begin
            rdy = ((q.size() == 0) && !mzero) || m_last();
            if (rdy && vin) begin
                m = a & b;
                q.delete();
                for (int i = 0; i < 8; i++)
                    if (m[i]) q.push_back(i);
                mzero = (m == 8'h00);
            end else begin
                if (q.size() > 0) void'(q.pop_front());
                mzero = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model valid", 32'(vout), 32'(m_valid()));
            chk("model addr",  32'(addr), 32'(m_addr()));
            chk("model last",  32'(last), 32'(m_last()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] x, input logic [7:0] y);
        vin = v;
        a   = x;
        b   = y;
    endtask

    task automatic expect_out(input string name, input logic v, input logic [2:0] ad, input logic l);
        chk({name, " valid"}, 32'(vout), 32'(v));
        chk({name, " addr"},  32'(addr), 32'(ad));
        chk({name, " last"},  32'(last), 32'(l));
    endtask

    initial begin
        // 1. Reset held with valid_i and random inputs
        rst = 1'b1;
        drive(1'b1, 8'($urandom), 8'($urandom));
        tick();
        chk_en = 1'b1;
        for (int i = 0; i < 50; i++) begin
            drive(1'b1, 8'($urandom), 8'($urandom));
            expect_out("reset", 1'b0, 3'd0, 1'b0);
            tick();
        end
        rst = 1'b0;
        drive(1'b0, 8'h00, 8'h00);
        tick();
        expect_out("idle", 1'b0, 3'd0, 1'b0);

        // 2. Multi-match scan: B4 & F6 = B4 -> 2,4,5,7
        drive(1'b1, 8'hB4, 8'hF6);
        tick();
        drive(1'b0, 8'h00, 8'h00);
        expect_out("multi0", 1'b1, 3'd2, 1'b0);
        tick(); expect_out("multi1", 1'b1, 3'd4, 1'b0);
        tick(); expect_out("multi2", 1'b1, 3'd5, 1'b0);
        tick(); expect_out("multi3", 1'b1, 3'd7, 1'b1);
        tick(); expect_out("multi_idle", 1'b0, 3'd0, 1'b0);

        // 3. Single match at top bit, then all-zero match
        drive(1'b1, 8'h80, 8'h80);
        tick();
        drive(1'b0, 8'h00, 8'h00);
        expect_out("single", 1'b1, 3'd7, 1'b1);
        tick(); expect_out("single_idle", 1'b0, 3'd0, 1'b0);
        drive(1'b1, 8'h0F, 8'hF0);
        tick();
        drive(1'b0, 8'h00, 8'h00);
        expect_out("zero", 1'b0, 3'd0, 1'b1);
        tick(); expect_out("zero_idle", 1'b0, 3'd0, 1'b0);

        // 4. Back-to-back: 81&FF then C0&C0 -> 0,7,6,7
        drive(1'b1, 8'h81, 8'hFF);
        tick(); expect_out("b2b0", 1'b1, 3'd0, 1'b0);
        tick(); expect_out("b2b1", 1'b1, 3'd7, 1'b1);
        drive(1'b1, 8'hC0, 8'hC0);
        tick(); expect_out("b2b2", 1'b1, 3'd6, 1'b0);
        drive(1'b0, 8'h00, 8'h00);
        tick(); expect_out("b2b3", 1'b1, 3'd7, 1'b1);
        tick(); expect_out("b2b_idle", 1'b0, 3'd0, 1'b0);

        // 5. valid_i while busy is ignored
        drive(1'b1, 8'hFF, 8'hFF);
        tick();
        drive(1'b0, 8'h00, 8'h00);
        for (int i = 0; i < 8; i++) begin
            expect_out("busy", 1'b1, 3'(i), (i == 7));
            if (i == 2) drive(1'b1, 8'h01, 8'h01);
            else        drive(1'b0, 8'h00, 8'h00);
            tick();
        end
        expect_out("busy_idle", 1'b0, 3'd0, 1'b0);

        // 6a. Reset mid-scan discards the rest of the vector
        drive(1'b1, 8'hFF, 8'hFF);
        tick();
        drive(1'b0, 8'h00, 8'h00);
        expect_out("pre_rst0", 1'b1, 3'd0, 1'b0);
        tick(); expect_out("pre_rst1", 1'b1, 3'd1, 1'b0);
        rst = 1'b1;
        drive(1'b1, 8'h0F, 8'h0F);
        tick(); expect_out("mid_rst", 1'b0, 3'd0, 1'b0);
        rst = 1'b0;
        drive(1'b0, 8'h00, 8'h00);
        tick(); expect_out("post_rst", 1'b0, 3'd0, 1'b0);
        tick(); expect_out("post_rst2", 1'b0, 3'd0, 1'b0);

        // 6b. Random soak, checked against the model every cycle
        for (int i = 0; i < 1000; i++) begin
            drive(($urandom_range(0, 3) != 0), 8'($urandom_range(128, 255)),
                  8'($urandom_range(128, 255)));
            tick();
        end
        drive(1'b0, 8'h00, 8'h00);
        repeat (10) tick();
        expect_out("final_idle", 1'b0, 3'd0, 1'b0);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
